// File: rtl/qupls_wrport_arb_pkg.sv
// qupls_wrport_arb_pkg: shared register-file writeback types, sizes and source numbers
package qupls_wrport_arb_pkg;

    localparam int ROB_ENTRIES = 32;
    localparam int NPREG       = 512;
    localparam int NWRPORT     = 2;
    localparam int NWBSRC      = 7;

    typedef logic [$clog2(NPREG)-1:0]       pregno_t;
    typedef logic [63:0]                    value_t;
    typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;

    typedef enum logic [2:0] {
        WB_ALU0,
        WB_ALU1,
        WB_FPU0,
        WB_FPU1,
        WB_FCU,
        WB_LD0,
        WB_LD1
    } wb_src_e;

endpackage

// File: rtl/qupls_rr_multigrant.sv
// qupls_rr_multigrant: rotating arbiter granting up to G requesters in scan order from ptr
module qupls_rr_multigrant #(
    parameter int N = 7,
    parameter int G = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(G + 1)
) (
    input  logic [N-1:0]          req,
    input  logic [IW-1:0]         ptr,
    output logic [N-1:0]          grant,
    output logic [G-1:0][IW-1:0]  gidx,
    output logic [CW-1:0]         gcnt,
    output logic [IW-1:0]         last
);

    logic [IW:0] s;

    // walk ptr, ptr+1, ... wrapping at N and take the first G active requesters
    always_comb begin
        grant = '0;
        gidx  = '0;
        gcnt  = '0;
        last  = ptr;
        s     = '0;
        for (int j = 0; j < N; j++) begin
            s = {1'b0, ptr} + (IW+1)'(j);
            if (s >= (IW+1)'(N))
                s = s - (IW+1)'(N);
            if (req[s[IW-1:0]] && gcnt < CW'(G)) begin
                grant[s[IW-1:0]] = 1'b1;
                for (int k = 0; k < G; k++)
                    if (gcnt == CW'(k))
                        gidx[k] = s[IW-1:0];
                gcnt = gcnt + CW'(1);
                last = s[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/qupls_wrport_arb.sv
// qupls_wrport_arb: holds FU results and drains them onto shared register-file write ports
module qupls_wrport_arb
    import qupls_wrport_arb_pkg::*;
#(
    parameter int NREQ  = NWBSRC,
    parameter int NPORT = NWRPORT,
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(NPORT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ROB_ENTRIES-1:0]   stomp_i,
    input  logic [NREQ-1:0]          req_v,
    output logic [NREQ-1:0]          req_rdy,
    input  pregno_t [NREQ-1:0]       req_pRt,
    input  value_t [NREQ-1:0]        req_res,
    input  rob_ndx_t [NREQ-1:0]      req_rndx,
    output logic [NREQ-1:0]          hold_full,
    output logic [NPORT-1:0]         wr_v,
    output pregno_t [NPORT-1:0]      wr_pRt,
    output value_t [NPORT-1:0]       wr_res,
    output rob_ndx_t [NPORT-1:0]     wr_rndx,
    output logic [NPORT-1:0][SW-1:0] wr_src
);

    logic [NREQ-1:0]          hold_v_q, hold_v_d;
    pregno_t [NREQ-1:0]       hold_pRt_q, hold_pRt_d;
    value_t [NREQ-1:0]        hold_res_q, hold_res_d;
    rob_ndx_t [NREQ-1:0]      hold_rndx_q, hold_rndx_d;
    logic [SW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NPORT-1:0]         wr_v_q, wr_v_d;
    pregno_t [NPORT-1:0]      wr_pRt_q, wr_pRt_d;
    value_t [NPORT-1:0]       wr_res_q, wr_res_d;
    rob_ndx_t [NPORT-1:0]     wr_rndx_q, wr_rndx_d;
    logic [NPORT-1:0][SW-1:0] wr_src_q, wr_src_d;

    logic [NREQ-1:0]          hold_stomp, elig, grant;
    logic [NPORT-1:0][SW-1:0] gidx;
    logic [CW-1:0]            gcnt;
    logic [SW-1:0]            last;

    // a held entry whose ROB slot is being flushed is not worth a write port
    always_comb begin
        hold_stomp = '0;
        elig       = '0;
        for (int i = 0; i < NREQ; i++) begin
            hold_stomp[i] = stomp_i[hold_rndx_q[i]];
            elig[i]       = hold_v_q[i] && !hold_stomp[i];
        end
    end

    qupls_rr_multigrant #(.N(NREQ), .G(NPORT)) u_arb (
        .req   (elig),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .gcnt  (gcnt),
        .last  (last)
    );

    // a slot can take a new result whenever its current occupant leaves this cycle
    always_comb begin
        req_rdy   = '0;
        hold_full = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rdy[i]   = !hold_v_q[i] || grant[i] || hold_stomp[i];
            hold_full[i] = hold_v_q[i] && !grant[i];
        end
    end

    // next holding state, registered write ports and pointer advance past the last grant
    always_comb begin
        hold_v_d    = hold_v_q & ~grant & ~hold_stomp;
        hold_pRt_d  = hold_pRt_q;
        hold_res_d  = hold_res_q;
        hold_rndx_d = hold_rndx_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_v[i] && req_rdy[i] && !stomp_i[req_rndx[i]]) begin
                hold_v_d[i]    = 1'b1;
                hold_pRt_d[i]  = req_pRt[i];
                hold_res_d[i]  = req_res[i];
                hold_rndx_d[i] = req_rndx[i];
            end
        end
        wr_v_d    = '0;
        wr_pRt_d  = '0;
        wr_res_d  = '0;
        wr_rndx_d = '0;
        wr_src_d  = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (gcnt > CW'(k)) begin
                wr_v_d[k]    = 1'b1;
                wr_pRt_d[k]  = hold_pRt_q[gidx[k]];
                wr_res_d[k]  = hold_res_q[gidx[k]];
                wr_rndx_d[k] = hold_rndx_q[gidx[k]];
                wr_src_d[k]  = gidx[k];
            end
        end
        rr_ptr_d = (gcnt == '0) ? rr_ptr_q : (last == SW'(NREQ - 1)) ? '0 : last + SW'(1);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q    <= '0;
            hold_pRt_q  <= '0;
            hold_res_q  <= '0;
            hold_rndx_q <= '0;
            rr_ptr_q    <= '0;
            wr_v_q      <= '0;
            wr_pRt_q    <= '0;
            wr_res_q    <= '0;
            wr_rndx_q   <= '0;
            wr_src_q    <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_pRt_q  <= hold_pRt_d;
            hold_res_q  <= hold_res_d;
            hold_rndx_q <= hold_rndx_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_v_q      <= wr_v_d;
            wr_pRt_q    <= wr_pRt_d;
            wr_res_q    <= wr_res_d;
            wr_rndx_q   <= wr_rndx_d;
            wr_src_q    <= wr_src_d;
        end
    end

    assign wr_v    = wr_v_q;
    assign wr_pRt  = wr_pRt_q;
    assign wr_res  = wr_res_q;
    assign wr_rndx = wr_rndx_q;
    assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_qupls_wrport_arb.sv
// tb_qupls_wrport_arb: directed and randomized checks of the write-port arbiter against a queue model
module tb_qupls_wrport_arb;
    import qupls_wrport_arb_pkg::*;

    localparam int NR = 7;
    localparam int NP = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [ROB_ENTRIES-1:0] stomp_i;
    logic [NR-1:0]          req_v, req_rdy, hold_full;
    pregno_t [NR-1:0]       req_pRt;
    value_t [NR-1:0]        req_res;
    rob_ndx_t [NR-1:0]      req_rndx;
    logic [NP-1:0]          wr_v;
    pregno_t [NP-1:0]       wr_pRt;
    value_t [NP-1:0]        wr_res;
    rob_ndx_t [NP-1:0]      wr_rndx;
    logic [NP-1:0][2:0]     wr_src;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qupls_wrport_arb #(.NREQ(NR), .NPORT(NP)) dut (
        .clk(clk), .rst(rst), .stomp_i(stomp_i),
        .req_v(req_v), .req_rdy(req_rdy), .req_pRt(req_pRt), .req_res(req_res), .req_rndx(req_rndx),
        .hold_full(hold_full),
        .wr_v(wr_v), .wr_pRt(wr_pRt), .wr_res(wr_res), .wr_rndx(wr_rndx), .wr_src(wr_src)
    );

    // reference model: one slot per source, a scan start, and queues of accepted values
    bit       m_hv[NR];
    pregno_t  m_p[NR];
    value_t   m_r[NR];
    rob_ndx_t m_x[NR];
    int       m_ptr;
    logic [NP-1:0] e_wv;
    int       e_src[NP];
    pregno_t  e_p[NP];
    value_t   e_r[NP];
    rob_ndx_t e_x[NP];
    logic [NR-1:0] e_rdy, e_full, o_rdy, o_full;
    value_t   sb[NR][$];

    task automatic tick();
        int order[$];
        bit g[NR];
        #2;
        o_rdy  = req_rdy;
        o_full = hold_full;
        for (int j = 0; j < NR; j++) begin
            int s;
            s = (m_ptr + j) % NR;
            if (m_hv[s] && !stomp_i[m_x[s]] && order.size() < NP) begin
                order.push_back(s);
                g[s] = 1;
            end
        end
        for (int i = 0; i < NR; i++) begin
            e_rdy[i]  = !m_hv[i] || g[i] || stomp_i[m_x[i]];
            e_full[i] = m_hv[i] && !g[i];
        end
        for (int k = 0; k < NP; k++) begin
            e_wv[k] = k < order.size();
            if (e_wv[k]) begin
                e_src[k] = order[k];
                e_p[k]   = m_p[order[k]];
                e_r[k]   = m_r[order[k]];
                e_x[k]   = m_x[order[k]];
            end
        end
        if (order.size() > 0) m_ptr = (order[$] + 1) % NR;
        for (int i = 0; i < NR; i++) begin
            if (g[i] || stomp_i[m_x[i]]) m_hv[i] = 0;
            if (req_v[i] && e_rdy[i] && !stomp_i[req_rndx[i]]) begin
                m_hv[i] = 1;
                m_p[i]  = req_pRt[i];
                m_r[i]  = req_res[i];
                m_x[i]  = req_rndx[i];
                sb[i].push_back(req_res[i]);
            end
        end
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_hv[i] = 0;
                sb[i].delete();
            end
            m_ptr = 0;
            e_wv  = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stomp_i  = '0;
        req_v    = '0;
        req_pRt  = '0;
        req_res  = '0;
        req_rndx = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_v !== 2'b00) begin failures++; $display("FAIL reset_wr_v got=%b exp=00", wr_v); end
        checks++; if (wr_res !== '0 || wr_pRt !== '0 || wr_rndx !== '0 || wr_src !== '0) begin failures++; $display("FAIL reset_wr_data got=%h/%h/%h/%h exp=0", wr_res, wr_pRt, wr_rndx, wr_src); end
        checks++; if (dut.rr_ptr_q !== 3'd0) begin failures++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr_q); end
        tick();
        checks++; if (o_rdy !== 7'h7f) begin failures++; $display("FAIL reset_req_rdy got=%b exp=1111111", o_rdy); end
        checks++; if (o_full !== 7'h00) begin failures++; $display("FAIL reset_hold_full got=%b exp=0000000", o_full); end
    endtask

    task automatic test_single();
        do_reset();
        req_v[0] = 1'b1; req_pRt[0] = 9'd5; req_res[0] = 64'h1234; req_rndx[0] = 5'd3;
        tick();
        req_v = '0;
        checks++; if (wr_v !== 2'b00) begin failures++; $display("FAIL single_early got=%b exp=00", wr_v); end
        tick();
        checks++; if (wr_v !== 2'b01) begin failures++; $display("FAIL single_wr_v got=%b exp=01", wr_v); end
        checks++; if (wr_pRt[0] !== 9'd5 || wr_res[0] !== 64'h1234 || wr_rndx[0] !== 5'd3 || wr_src[0] !== 3'd0) begin failures++; $display("FAIL single_data got=%0d/%h/%0d/%0d exp=5/1234/3/0", wr_pRt[0], wr_res[0], wr_rndx[0], wr_src[0]); end
        checks++; if (dut.rr_ptr_q !== 3'd1) begin failures++; $display("FAIL single_rr_ptr got=%0d exp=1", dut.rr_ptr_q); end
    endtask

    task automatic test_three();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_pRt[i] = pregno_t'(20 + i); req_res[i] = value_t'(100 + i); req_rndx[i] = rob_ndx_t'(10 + i);
        end
        req_v = 7'b0010101;
        tick();
        req_v = '0;
        tick();
        checks++; if (wr_v !== 2'b11 || wr_src[0] !== 3'd0 || wr_src[1] !== 3'd2) begin failures++; $display("FAIL three_c1 got=%b src=%0d,%0d exp=11 src=0,2", wr_v, wr_src[0], wr_src[1]); end
        checks++; if (wr_pRt[1] !== 9'd22 || wr_res[1] !== 64'd102) begin failures++; $display("FAIL three_c1_data got=%0d/%0d exp=22/102", wr_pRt[1], wr_res[1]); end
        checks++; if (o_full !== 7'b0010000) begin failures++; $display("FAIL three_hold_full got=%b exp=0010000", o_full); end
        tick();
        checks++; if (wr_v !== 2'b01 || wr_src[0] !== 3'd4) begin failures++; $display("FAIL three_c2 got=%b src=%0d exp=01 src=4", wr_v, wr_src[0]); end
        checks++; if (dut.rr_ptr_q !== 3'd5) begin failures++; $display("FAIL three_rr_ptr got=%0d exp=5", dut.rr_ptr_q); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_v[3] = 1'b1; req_pRt[3] = 9'd40; req_rndx[3] = 5'd1; req_res[3] = 64'hAAAA_0001;
        tick();
        checks++; if (o_rdy[3] !== 1'b1) begin failures++; $display("FAIL b2b_rdy_a got=%b exp=1", o_rdy[3]); end
        req_res[3] = 64'hBBBB_0002; req_rndx[3] = 5'd2;
        tick();
        checks++; if (o_rdy[3] !== 1'b1) begin failures++; $display("FAIL b2b_rdy_b got=%b exp=1", o_rdy[3]); end
        checks++; if (wr_v !== 2'b01 || wr_res[0] !== 64'hAAAA_0001 || wr_src[0] !== 3'd3) begin failures++; $display("FAIL b2b_a got=%b/%h/%0d exp=01/aaaa0001/3", wr_v, wr_res[0], wr_src[0]); end
        req_v = '0;
        tick();
        checks++; if (wr_v !== 2'b01 || wr_res[0] !== 64'hBBBB_0002 || wr_rndx[0] !== 5'd2) begin failures++; $display("FAIL b2b_b got=%b/%h/%0d exp=01/bbbb0002/2", wr_v, wr_res[0], wr_rndx[0]); end
        tick();
        checks++; if (wr_v !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", wr_v); end
    endtask

    task automatic test_stomp();
        int n1, nall;
        n1 = 0; nall = 0;
        do_reset();
        req_v[1] = 1'b1; req_rndx[1] = 5'd2; req_res[1] = 64'h11;
        tick();
        req_v = '0;
        tick();
        for (int i = 1; i < 6; i++) begin
            req_rndx[i] = rob_ndx_t'(10 + i); req_res[i] = value_t'(200 + i);
        end
        req_rndx[1] = 5'd7;
        req_v = 7'b0111110;
        tick();
        req_v = '0;
        stomp_i[7] = 1'b1;
        tick();
        stomp_i = '0;
        checks++; if (o_rdy[1] !== 1'b1) begin failures++; $display("FAIL stomp_rdy got=%b exp=1", o_rdy[1]); end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < NP; k++) if (wr_v[k]) begin
                nall++;
                if (wr_src[k] == 3'd1) n1++;
            end
            tick();
        end
        checks++; if (n1 != 0) begin failures++; $display("FAIL stomp_written got=%0d writes of src1 exp=0", n1); end
        checks++; if (nall != 4) begin failures++; $display("FAIL stomp_others got=%0d writes exp=4", nall); end
        checks++; if (o_full !== 7'h00) begin failures++; $display("FAIL stomp_drained got=%b exp=0000000", o_full); end
    endtask

    task automatic test_rst_mid();
        int nw;
        nw = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_rndx[i] = rob_ndx_t'(i); req_res[i] = value_t'(300 + i);
        end
        req_v = 7'b0001111;
        tick();
        req_v = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (wr_v !== 2'b00) begin failures++; $display("FAIL rstmid_wr_v got=%b exp=00", wr_v); end
        tick();
        checks++; if (o_full !== 7'h00) begin failures++; $display("FAIL rstmid_hold_full got=%b exp=0000000", o_full); end
        checks++; if (o_rdy !== 7'h7f) begin failures++; $display("FAIL rstmid_req_rdy got=%b exp=1111111", o_rdy); end
        for (int c = 0; c < 3; c++) begin
            if (wr_v != 0) nw++;
            tick();
        end
        checks++; if (nw != 0) begin failures++; $display("FAIL rstmid_late_writes got=%0d exp=0", nw); end
    endtask

    task automatic test_saturation();
        int last[NR];
        int nw;
        do_reset();
        for (int i = 0; i < NR; i++) last[i] = 1;
        for (int c = 1; c <= 25; c++) begin
            req_v = (c <= 20) ? 7'h7f : 7'h00;
            for (int i = 0; i < NR; i++) begin
                req_pRt[i] = pregno_t'($urandom); req_res[i] = {$urandom, $urandom}; req_rndx[i] = rob_ndx_t'($urandom);
            end
            tick();
            nw = 0;
            checks++; if (wr_v !== e_wv) begin failures++; $display("FAIL sat_wr_v c=%0d got=%b exp=%b", c, wr_v, e_wv); end
            for (int k = 0; k < NP; k++) if (wr_v[k]) begin
                nw++;
                checks++;
                if (int'(wr_src[k]) >= NR || sb[wr_src[k]].size() == 0) begin
                    failures++; $display("FAIL sat_scoreboard c=%0d src=%0d got=%h exp=none_pending", c, wr_src[k], wr_res[k]);
                end else begin
                    value_t v;
                    v = sb[wr_src[k]].pop_front();
                    if (wr_res[k] !== v) begin failures++; $display("FAIL sat_scoreboard c=%0d src=%0d got=%h exp=%h", c, wr_src[k], wr_res[k], v); end
                    last[wr_src[k]] = c;
                end
            end
            if (c >= 2 && c <= 20) begin
                int worst;
                worst = 0;
                for (int i = 0; i < NR; i++) if (c - last[i] > worst) worst = c - last[i];
                checks++; if (nw != 2) begin failures++; $display("FAIL sat_two_ports c=%0d got=%0d exp=2", c, nw); end
                checks++; if (wr_src[0] === wr_src[1]) begin failures++; $display("FAIL sat_dup c=%0d got=%0d,%0d exp=distinct", c, wr_src[0], wr_src[1]); end
                checks++; if (worst > 4) begin failures++; $display("FAIL sat_starve c=%0d got=%0d exp<=4", c, worst); end
            end
        end
        nw = 0;
        for (int i = 0; i < NR; i++) nw += sb[i].size();
        checks++; if (nw != 0) begin failures++; $display("FAIL sat_lost got=%0d pending exp=0", nw); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 150; c++) begin
            req_v   = NR'($urandom);
            stomp_i = ($urandom_range(0, 2) == 0) ? (ROB_ENTRIES'(1) << $urandom_range(0, 7)) : '0;
            for (int i = 0; i < NR; i++) begin
                req_pRt[i] = pregno_t'($urandom); req_res[i] = {$urandom, $urandom}; req_rndx[i] = rob_ndx_t'($urandom_range(0, 7));
            end
            tick();
            checks++; if (o_rdy !== e_rdy) begin failures++; $display("FAIL rnd_req_rdy c=%0d got=%b exp=%b", c, o_rdy, e_rdy); end
            checks++; if (o_full !== e_full) begin failures++; $display("FAIL rnd_hold_full c=%0d got=%b exp=%b", c, o_full, e_full); end
            checks++; if (wr_v !== e_wv) begin failures++; $display("FAIL rnd_wr_v c=%0d got=%b exp=%b", c, wr_v, e_wv); end
            for (int k = 0; k < NP; k++) if (e_wv[k]) begin
                checks++;
                if (wr_src[k] !== 3'(e_src[k]) || wr_pRt[k] !== e_p[k] || wr_res[k] !== e_r[k] || wr_rndx[k] !== e_x[k]) begin
                    failures++;
                    $display("FAIL rnd_port%0d c=%0d got=%0d/%0d/%h/%0d exp=%0d/%0d/%h/%0d", k, c, wr_src[k], wr_pRt[k], wr_res[k], wr_rndx[k], e_src[k], e_p[k], e_r[k], e_x[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_back_to_back();
        test_stomp();
        test_rst_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qupls_wrport_arb.md
Name: qupls_wrport_arb

Overview:
- Shares NPORT register-file write ports among NREQ functional-unit result sources (ALU0, ALU1, FPU0, FPU1, FCU, AGEN/load0, load1).
- Sits between the FU outputs and the physical register file / ROB done-update.
- Each requester has a one-entry holding register. A rotating multi-grant arbiter drains held results onto the write ports.
- Hold-full status is fed back to the scheduler's *_idle inputs, so no new op issues to a unit whose result is still stuck.

Parameters:
- NREQ, 7, number of result sources.
- NPORT, 2, number of register-file write ports (1..NREQ).
- ROB_ENTRIES, from QuplsPkg, width of the stomp mask.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stomp_i  in  ROB_ENTRIES  ROB entries being flushed this cycle.
- req_v  in  NREQ  result valid, per source.
- req_rdy  out  NREQ  holding register can accept this cycle.
- req_pRt  in  NREQ x pregno_t  destination physical register.
- req_res  in  NREQ x value_t  result value.
- req_rndx  in  NREQ x rob_ndx_t  ROB index of the producing op.
- hold_full  out  NREQ  holding register occupied and not granted this cycle (to scheduler idle logic).
- wr_v  out  NPORT  write port valid.
- wr_pRt  out  NPORT x pregno_t  write port register.
- wr_res  out  NPORT x value_t  write port data.
- wr_rndx  out  NPORT x rob_ndx_t  ROB index to mark done.
- wr_src  out  NPORT x $clog2(NREQ)  granted source number (debug/perf).

Behaviour:
- Reset, synchronous on clk when rst=1:
  - hold_v=0 and rr_ptr=0.
  - All wr_* outputs = 0, all hold data = 0.
  - The first cycle after reset: req_rdy all 1, hold_full all 0.
- State:
  - Per source: hold_v, hold_pRt, hold_res, hold_rndx.
  - Round-robin pointer rr_ptr, 0..NREQ-1.
- Arbitration (combinational, from hold_v and rr_ptr only, never from req_v):
  - Scan sources rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Grant the first min(NPORT, popcount(eligible)) entries.
  - Eligible = hold_v && !stomp_i[hold_rndx].
  - Port k carries the k-th grant in scan order; unused ports have wr_v=0 next cycle.
- req_rdy[i] = !hold_v[i] || grant[i] || stomp_i[hold_rndx[i]].
  - This gives full throughput: one result per source per cycle when granted every cycle.
- Clock edge, per source i:
  - req_v&&req_rdy&&!stomp_i[req_rndx]: load hold, hold_v=1.
  - Else if the entry is granted or stomped: hold_v=0.
  - A stomped incoming request is accepted (handshake completes) and discarded.
- Write ports are registered: wr_* at edge T+1 reflects grants computed during cycle T.
  - Minimum latency req_v→wr_v is 2 edges: capture, then grant.
- rr_ptr update: when at least one grant, rr_ptr = (index of last granted source + 1) mod NREQ. No grants leaves rr_ptr unchanged.
  - Guarantees starvation freedom: a held entry is granted within ceil(NREQ/NPORT) cycles.
- Stomp after grant, while wr_v is already registered: the write proceeds. Committing a stomped speculative preg is harmless; the ROB ignores done for invalid entries.
- hold_full[i] = hold_v[i] && !grant[i].
- All sources held with NPORT=2: exactly 2 write-port transfers per cycle, no duplicates, and no source granted twice in one cycle.
- rst asserted mid-operation: held results are dropped and wr_v cleared on the same edge.

Decomposition:
- QuplsPkg (existing shared package):
  - pregno_t, value_t, rob_ndx_t.
  - Source-number constants WB_ALU0..WB_LD1.
  - NWRPORT default.
- One sub-module, qupls_rr_multigrant (parameters N, G):
  - Inputs: req[N], ptr.
  - Outputs: grant[N], grant index list [G], grant count, last-granted index.
  - Pure combinational; unit-testable on its own.

Test Plan:
- Single source: req_v[0]=1, pRt=5, res=0x1234, rndx=3 for one cycle.
  - Expect wr_v[0]=1 two edges later with pRt=5, res=0x1234, rndx=3, wr_src=0.
  - Expect wr_v[1]=0 and rr_ptr=1.
- Three simultaneous sources 0, 2, 4 from reset, NPORT=2.
  - Cycle 1: ports carry src 0 and 2; hold_full[4]=1.
  - Next cycle: src 4 alone; rr_ptr ends at 5.
- Saturation: all 7 sources assert req_v every cycle for 20 cycles.
  - Expect 2 wr_v per cycle with no duplicate source in a cycle.
  - Expect every source granted at least once per 4 cycles.
  - Expect no lost or duplicated results (scoreboard).
- Stomp while held: src 1 held with rndx=7, ports busy; stomp_i[7]=1 for one cycle.
  - Expect the entry dropped, never written, and req_rdy[1]=1 that cycle.
- Back-to-back: src 3 sends values A and B on consecutive cycles with only src 3 active.
  - Expect req_rdy[3] to stay 1.
  - Expect wr outputs A then B on consecutive cycles.
- rst asserted with 4 entries held.
  - Next cycle: wr_v=0, hold_full=0, req_rdy all 1, and nothing is written afterwards.
